// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: channel state encoding,
// counter sizing helper and parameter defaults.
package debounce_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } ch_state_e;

   localparam int DEF_CHANNELS      = 4;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 16;
   localparam int DEF_SAMPLE_DIV    = 1;

   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser, stability counter FSM and edge pulses.
// The FSM only advances on sample ticks; the synchroniser runs every clock.
//
// state | meaning
// IDLE  | synchronised input matches z, counter cleared
// COUNT | input differs from z, cnt = consecutive differing ticks so far
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic x_i,
   output logic z_o,
   output logic rise_o,
   output logic fall_o,
   output logic pulse_d_o
);

   localparam int CW = cnt_width(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   ch_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   commit;
   logic                   z_q, z_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], x_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      if (tick_i) begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (s != z_q) begin
                  if (STABLE_CYCLES == 1) begin
                     commit = 1'b1;
                  end else begin
                     state_d = COUNT;
                     cnt_d   = CW'(1);
                  end
               end
            end
            COUNT: begin
               if (s == z_q) begin
                  // Glitch: input came back before it was stable long enough.
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                  commit  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Pulses are registered with z so they coincide with its first new cycle.
   always_comb begin
      z_d    = commit ? s : z_q;
      rise_d = commit & s;
      fall_d = commit & ~s;
   end

   assign z_o       = z_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign pulse_d_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-rate prescaler, one debounce_channel
// per input bit, and a registered "any edge" flag aligned with the pulses.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = DEF_CHANNELS,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] x,
   output logic [CHANNELS-1:0] z,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_multi: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("debounce_multi: STABLE_CYCLES must be >= 1");
   end
   if (SAMPLE_DIV < 1) begin : g_bad_div
      $error("debounce_multi: SAMPLE_DIV must be >= 1");
   end

   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [DW-1:0]       div_q, div_d;
   logic                tick;
   logic [CHANNELS-1:0] pulse_d;
   logic                changed_q;

   assign tick  = (div_q == DW'(SAMPLE_DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         div_q     <= div_d;
         changed_q <= |pulse_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick_i   (tick),
         .x_i      (x[i]),
         .z_o      (z[i]),
         .rise_o   (rise[i]),
         .fall_o   (fall[i]),
         .pulse_d_o(pulse_d[i])
      );
   end

   assign changed = changed_q;

endmodule
